line_clear: RTL

- Post-lock line-clear engine for the Tetris playfield. Sits directly upstream of the playfield matrix register file.
- Reads the full matrix snapshot and finds completed rows. Compacts the surviving rows downward through the matrix's single row-write port, then zero-fills the vacated top rows.
- Reports the number of lines cleared to the scoring/level logic.

---
 rtl/line_clear.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/line_clear.sv
// line_clear: post-lock line-clear engine for the playfield matrix.
//
// Scans the live matrix snapshot from the bottom row to the top. Surviving
// (non-full) rows are copied down through the matrix row-write port. The
// vacated top rows are then zero-filled. The number of cleared rows is reported.
//
// Matrix packing: row r occupies matrix_i[r*width_p*depth_p +: width_p*depth_p],
// and column c of a row occupies row[c*depth_p +: depth_p]. Row 0 is the top row.
//
// Ports:
//   clk_i           clock
//   reset_i         synchronous active-high reset
//   start_i         start a clear pass (only accepted while ready_o=1)
//   ready_o         high in IDLE
//   matrix_i        live playfield contents
//   set_row_addr_o  row written when set_v_o=1
//   set_row_data_o  data written when set_v_o=1
//   set_v_o         row write strobe (matrix commits on the next posedge)
//   done_o          one-cycle pulse at the end of a pass
//   lines_cleared_o row count from the last completed pass
//
// state | meaning
// IDLE  | waiting for start_i, ready_o=1
// SCAN  | one row per cycle, bottom to top, compacting survivors downward
// FILL  | zero-fill rows cnt-1 down to 0
// DONE  | one-cycle done_o pulse, publish the count
module line_clear #(
  parameter int width_p  = 10,
  parameter int height_p = 20,
  parameter int depth_p  = 2
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  output logic                                  ready_o,
  input  logic [height_p*width_p*depth_p-1:0]   matrix_i,
  output logic [$clog2(height_p)-1:0]           set_row_addr_o,
  output logic [width_p*depth_p-1:0]            set_row_data_o,
  output logic                                  set_v_o,
  output logic                                  done_o,
  output logic [$clog2(height_p+1)-1:0]         lines_cleared_o
);

  localparam int row_w_lp  = width_p * depth_p;
  localparam int addr_w_lp = $clog2(height_p);
  localparam int cnt_w_lp  = $clog2(height_p + 1);
  localparam logic [addr_w_lp-1:0] last_row_lp = addr_w_lp'(height_p - 1);

  typedef enum logic [1:0] {IDLE, SCAN, FILL, DONE} state_e;

  state_e                state_r, state_n;
  logic [addr_w_lp-1:0]  rd_r, rd_n;
  logic [addr_w_lp-1:0]  wr_r, wr_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic [cnt_w_lp-1:0]   lines_r, lines_n;

  logic [row_w_lp-1:0]   rd_row;
  logic                  row_full;
  logic                  wr_v;
  logic [addr_w_lp-1:0]  wr_addr;
  logic [row_w_lp-1:0]   wr_data;
  logic                  done_v;

  assign rd_row = matrix_i[int'(rd_r) * row_w_lp +: row_w_lp];

  always_comb begin
    row_full = 1'b1;
    for (int c = 0; c < width_p; c++) begin
      if (rd_row[c*depth_p +: depth_p] == '0) row_full = 1'b0;
    end
  end

  always_comb begin
    state_n = state_r;
    rd_n    = rd_r;
    wr_n    = wr_r;
    cnt_n   = cnt_r;
    lines_n = lines_r;
    ready_o = 1'b0;
    wr_v    = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    done_v  = 1'b0;

    case (state_r)
      IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          state_n = SCAN;
          rd_n    = last_row_lp;
          wr_n    = last_row_lp;
          cnt_n   = '0;
        end
      end

      SCAN: begin
        if (row_full) begin
          cnt_n = cnt_r + 1'b1;
        end else begin
          // A survivor that is already in place needs no write.
          if (wr_r != rd_r) begin
            wr_v    = 1'b1;
            wr_addr = wr_r;
            wr_data = rd_row;
          end
          if (wr_r != '0) wr_n = wr_r - 1'b1;
        end
        if (rd_r == '0) begin
          state_n = (cnt_n == '0) ? DONE : FILL;
        end else begin
          rd_n = rd_r - 1'b1;
        end
      end

      // At the end of SCAN wr_r has settled at cnt-1, the topmost vacated row.
      FILL: begin
        wr_v    = 1'b1;
        wr_addr = wr_r;
        wr_data = '0;
        if (wr_r == '0) state_n = DONE;
        else            wr_n    = wr_r - 1'b1;
      end

      DONE: begin
        done_v  = 1'b1;
        lines_n = cnt_r;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  // Block the write strobe while reset_i is asserted. An interrupted pass
  // then cannot commit one more row in the reset cycle.
  assign set_v_o         = wr_v & ~reset_i;
  assign set_row_addr_o  = set_v_o ? wr_addr : '0;
  assign set_row_data_o  = set_v_o ? wr_data : '0;
  assign done_o          = done_v & ~reset_i;
  assign lines_cleared_o = lines_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      rd_r    <= '0;
      wr_r    <= '0;
      cnt_r   <= '0;
      lines_r <= '0;
    end else begin
      state_r <= state_n;
      rd_r    <= rd_n;
      wr_r    <= wr_n;
      cnt_r   <= cnt_n;
      lines_r <= lines_n;
    end
  end

endmodule
